// File: rtl/fetch_queue.sv
// Prefetching 6502 instruction fetcher: byte queue plus length decode.
// Optional FETCH_PERF_EN adds perf_instr / perf_stall counters.
`ifndef INSTRUCTION_BASE
`define INSTRUCTION_BASE '0
`endif

module fetch_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = `INSTRUCTION_BASE
) (
    input  logic                   phi1,
    input  logic                   reset,
    input  logic                   halt,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [REG_WIDTH-1:0]   mem_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [REG_WIDTH-1:0]   opcode,
    output logic [2*REG_WIDTH-1:0] operand,
    output logic [1:0]             instr_len,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [ADDR_WIDTH-1:0]  pc_next
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]            perf_instr,
    output logic [15:0]            perf_stall
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [REG_WIDTH-1:0]  q_data [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr [DEPTH];

    logic [PW-1:0]         head;
    logic [CW-1:0]         count;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [ADDR_WIDTH-1:0] fetch_pc;

    logic                  fetch_en;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [1:0]            len;
    logic [PW-1:0]         tail;
    logic [PW-1:0]         idx1;
    logic [PW-1:0]         idx2;

    // Circular index: base + off never reaches 2*DEPTH here.
    function automatic logic [PW-1:0] slot(
        input logic [PW-1:0] base,
        input int            off
    );
        int s;
        s = int'(base) + off;
        if (s >= DEPTH)
            s = s - DEPTH;
        return PW'(s);
    endfunction

    function automatic logic [1:0] decode_len(
        input logic [REG_WIDTH-1:0] op
    );
        logic [1:0] n;
        n = 2'd1;
        unique case (op[1:0])
            2'b01: begin
                if (op[4:2] == 3'b011 || op[4:2] == 3'b110 ||
                    op[4:2] == 3'b111)
                    n = 2'd3;
                else
                    n = 2'd2;
            end
            2'b11: n = 2'd1;
            default: begin
                case (op[4:2])
                    3'b000: begin
                        if (op == REG_WIDTH'('h20))
                            n = 2'd3;
                        else if (op == '0 ||
                                 op == REG_WIDTH'('h40) ||
                                 op == REG_WIDTH'('h60))
                            n = 2'd1;
                        else
                            n = 2'd2;
                    end
                    3'b001, 3'b101: n = 2'd2;
                    3'b010, 3'b110: n = 2'd1;
                    3'b011, 3'b111: n = 2'd3;
                    default: n = op[1] ? 2'd1 : 2'd2;
                endcase
            end
        endcase
        return n;
    endfunction

    always_ff @(posedge phi1) begin
        if (reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // halt takes effect in the same cycle it is raised.
    always_comb begin
        state_next = state;
        if (halt)
            state_next = HALTED;
        else
            state_next = RUN;
        fetch_en = (state_next == RUN);
    end

    always_comb begin
        tail  = slot(head, int'(count));
        idx1  = slot(head, 1);
        idx2  = slot(head, 2);
        len   = decode_len(q_data[head]);
        instr_valid = (count != '0) &&
                      (int'(count) >= int'(len));
        issue = fetch_en && !redirect && !reset &&
                (int'(count) + int'(pending) < DEPTH);
        push  = pending && !redirect && !reset;
        pop   = instr_valid && instr_ready &&
                !redirect && !reset;
        mem_rd   = issue;
        mem_addr = fetch_pc;
    end

    always_comb begin
        opcode    = '0;
        operand   = '0;
        instr_len = 2'd1;
        instr_pc  = '0;
        pc_next   = '0;
        if (instr_valid) begin
            opcode    = q_data[head];
            instr_len = len;
            instr_pc  = q_addr[head];
            pc_next   = q_addr[head] + ADDR_WIDTH'(len);
            if (len == 2'd3)
                operand = {q_data[idx2], q_data[idx1]};
            else if (len == 2'd2)
                operand = {{REG_WIDTH{1'b0}}, q_data[idx1]};
        end
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            head      <= '0;
            count     <= '0;
            pending   <= 1'b0;
            pend_addr <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            count    <= '0;
            pending  <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc  <= fetch_pc + ADDR_WIDTH'(1);
                pend_addr <= fetch_pc;
            end
            pending <= issue;
            if (pop)
                head <= slot(head, int'(len));
            count <= CW'(int'(count) + int'(push) -
                         (pop ? int'(len) : 0));
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge phi1) begin
        if (push) begin
            q_data[tail] <= mem_data;
            q_addr[tail] <= pend_addr;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge phi1) begin
        if (reset) begin
            perf_instr <= '0;
            perf_stall <= '0;
        end else begin
            if (pop && perf_instr != 16'hFFFF)
                perf_instr <= perf_instr + 16'd1;
            if (instr_ready && !instr_valid &&
                perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [15:0] RST_PC = 16'h8000;

    logic        phi1 = 1'b0;
    logic        reset, halt, redirect;
    logic [15:0] redirect_pc;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        instr_valid, instr_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc, pc_next;

    fetch_queue #(
        .ADDR_WIDTH(16),
        .REG_WIDTH(8),
        .DEPTH(DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .phi1(phi1),
        .reset(reset),
        .halt(halt),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode(opcode),
        .operand(operand),
        .instr_len(instr_len),
        .instr_pc(instr_pc),
        .pc_next(pc_next)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } qent_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  len;
        logic [15:0] nxt;
    } acc_t;

    logic [7:0]  mem [65536];
    qent_t       mq[$];
    acc_t        acc[$];
    logic [15:0] m_pc, m_pend_addr;
    bit          m_pend;
    bit          known;
    int          nchk, nerr;
    bit          last_rd, last_valid;
    logic [15:0] last_addr, last_opd;
    logic [7:0]  last_op;
    logic [1:0]  last_len;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] b;
        cc = op[1:0];
        b  = op[4:2];
        if (cc == 2'd3) return 1;
        if (cc == 2'd1) return (b == 3 || b == 6 || b == 7) ? 3 : 2;
        if (b == 0) begin
            if (op == 8'h20) return 3;
            if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
            return 2;
        end
        if (b == 1 || b == 5) return 2;
        if (b == 2 || b == 6) return 1;
        if (b == 3 || b == 7) return 3;
        return (cc == 2'd0) ? 2 : 1;
    endfunction

    task automatic step(input bit rst, input bit hlt, input bit rdr,
                        input logic [15:0] rpc, input bit rdy);
        int          l;
        bit          v, rd;
        logic [15:0] eopd;
        @(negedge phi1);
        reset       = rst;
        halt        = hlt;
        redirect    = rdr;
        redirect_pc = rpc;
        instr_ready = rdy;
        mem_data    = m_pend ? mem[m_pend_addr] : 8'($urandom);
        #1;
        l  = (mq.size() > 0) ? ref_len(mq[0].d) : 1;
        v  = (mq.size() > 0) && (mq.size() >= l);
        rd = !rst && !hlt && !rdr && (mq.size() + int'(m_pend) < DEPTH);
        eopd = 16'h0;
        if (v && l == 3) eopd = {mq[2].d, mq[1].d};
        else if (v && l == 2) eopd = {8'h00, mq[1].d};
        if (known) begin
            chk("mem_rd", mem_rd, rd);
            if (rd) chk("mem_addr", mem_addr, m_pc);
            chk("instr_valid", instr_valid, v);
            if (v) begin
                chk("opcode", opcode, mq[0].d);
                chk("operand", operand, eopd);
                chk("instr_len", instr_len, l);
                chk("instr_pc", instr_pc, mq[0].a);
                chk("pc_next", pc_next, 16'(mq[0].a + 16'(l)));
            end else begin
                chk("idle_opcode", opcode, 0);
                chk("idle_operand", operand, 0);
                chk("idle_len", instr_len, 1);
                chk("idle_pc", instr_pc, 0);
                chk("idle_pc_next", pc_next, 0);
            end
        end
        if (v && rdy && !rdr && !rst)
            acc.push_back('{instr_pc, opcode, operand, instr_len, pc_next});
        last_rd    = mem_rd;
        last_addr  = mem_addr;
        last_valid = instr_valid;
        last_op    = opcode;
        last_opd   = operand;
        last_len   = instr_len;
        @(posedge phi1);
        if (rst) begin
            mq.delete();
            m_pc   = RST_PC;
            m_pend = 1'b0;
            known  = 1'b1;
        end else if (rdr) begin
            mq.delete();
            m_pc   = rpc;
            m_pend = 1'b0;
        end else begin
            if (v && rdy)
                repeat (l) void'(mq.pop_front());
            if (m_pend)
                mq.push_back('{m_pend_addr, mem_data});
            m_pend = rd;
            if (rd) begin
                m_pend_addr = m_pc;
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    initial begin
        int vcnt, rdc, hcnt;
        nchk = 0;
        nerr = 0;
        known = 1'b0;
        m_pend = 1'b0;
        m_pc = RST_PC;
        m_pend_addr = 16'h0;
        foreach (mem[i]) mem[i] = 8'($urandom);
        reset = 1'b1; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0; instr_ready = 1'b0; mem_data = 8'h0;

        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h05;
        for (int i = 2; i < 10; i++) mem[16'h8000 + 16'(i)] = 8'hEA;
        step(1, 0, 0, 16'h0, 1);
        step(1, 0, 0, 16'h0, 1);
        acc.delete();
        step(0, 0, 0, 16'h0, 1);
        chk("a_first_rd", last_rd, 1);
        chk("a_first_addr", last_addr, 16'h8000);
        repeat (7) step(0, 0, 0, 16'h0, 1);
        chk("a_accepts", acc.size() >= 2, 1);
        if (acc.size() >= 2) begin
            chk("a0_op", acc[0].op, 8'hA9);
            chk("a0_opd", acc[0].opd, 16'h0005);
            chk("a0_len", acc[0].len, 2);
            chk("a0_pc", acc[0].pc, 16'h8000);
            chk("a0_nxt", acc[0].nxt, 16'h8002);
            chk("a1_op", acc[1].op, 8'hEA);
            chk("a1_len", acc[1].len, 1);
            chk("a1_pc", acc[1].pc, 16'h8002);
        end

        mem[16'hC000] = 8'h4C;
        mem[16'hC001] = 8'h34;
        mem[16'hC002] = 8'h12;
        step(0, 0, 1, 16'hC000, 0);
        repeat (12) step(0, 0, 0, 16'h0, 0);
        chk("b_valid", last_valid, 1);
        chk("b_op", last_op, 8'h4C);
        chk("b_opd", last_opd, 16'h1234);
        chk("b_len", last_len, 3);
        chk("b_full_rd", last_rd, 0);

        for (int i = 0; i < 64; i++) mem[16'hA000 + 16'(i)] = 8'hEA;
        step(0, 0, 1, 16'hA000, 1);
        repeat (10) step(0, 0, 0, 16'h0, 1);
        acc.delete();
        vcnt = 0;
        repeat (10) begin
            step(0, 0, 0, 16'h0, 1);
            vcnt += int'(last_valid);
        end
        chk("c_rate", vcnt, 10);
        if (acc.size() >= 2)
            chk("c_pc_step",
                16'(acc[acc.size()-1].pc - acc[acc.size()-2].pc), 1);

        for (int i = 0; i < 16; i++) begin
            mem[16'hB000 + 16'(i)] = 8'hEA;
            mem[16'h9000 + 16'(i)] = 8'hEA;
        end
        step(0, 0, 1, 16'hB000, 1);
        repeat (5) step(0, 0, 0, 16'h0, 1);
        acc.delete();
        step(0, 0, 1, 16'h9000, 1);
        chk("d_valid_at_redirect", last_valid, 1);
        chk("d_no_rd_at_redirect", last_rd, 0);
        step(0, 0, 0, 16'h0, 1);
        chk("d_rd", last_rd, 1);
        chk("d_addr", last_addr, 16'h9000);
        repeat (4) step(0, 0, 0, 16'h0, 1);
        chk("d_accepts", acc.size() > 0, 1);
        if (acc.size() > 0) chk("d_pc", acc[0].pc, 16'h9000);

        mem[16'hFFFE] = 8'hAD;
        mem[16'hFFFF] = 8'h10;
        mem[16'h0000] = 8'h20;
        acc.delete();
        step(0, 0, 1, 16'hFFFE, 1);
        repeat (6) step(0, 0, 0, 16'h0, 1);
        chk("e_accepts", acc.size() > 0, 1);
        if (acc.size() > 0) begin
            chk("e_op", acc[0].op, 8'hAD);
            chk("e_opd", acc[0].opd, 16'h2010);
            chk("e_len", acc[0].len, 3);
            chk("e_pc", acc[0].pc, 16'hFFFE);
            chk("e_nxt", acc[0].nxt, 16'h0001);
        end

        mem[16'hD000] = 8'hEA;
        step(0, 0, 1, 16'hD000, 0);
        step(0, 0, 0, 16'h0, 0);
        chk("f_issue", last_rd, 1);
        rdc = 0;
        repeat (5) begin
            step(0, 1, 0, 16'h0, 0);
            rdc += int'(last_rd);
        end
        chk("f_halt_reads", rdc, 0);
        chk("f_queued_valid", last_valid, 1);
        chk("f_queued_op", last_op, 8'hEA);
        step(0, 0, 0, 16'h0, 0);
        chk("f_resume_rd", last_rd, 1);
        chk("f_resume_addr", last_addr, 16'hD001);

        foreach (mem[i]) mem[i] = 8'($urandom);
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          r, h, d;
            logic [15:0] p;
            r = ($urandom_range(0, 199) == 0);
            h = 1'b0;
            if (hcnt > 0) begin
                hcnt--;
                h = 1'b1;
            end else if ($urandom_range(0, 19) == 0) begin
                hcnt = $urandom_range(1, 6);
            end
            d = ($urandom_range(0, 39) == 0);
            p = ($urandom_range(0, 3) == 0) ?
                16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            step(r, h, d, p, $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
